// File: rtl/rx_engine_pkg.sv
// Shared definitions for the UART receive path: the baud divisor table,
// CPU port addresses, FSM state encodings and a parity helper.
package rx_engine_pkg;

  localparam logic [15:0] RX_DATA_PORT_DEFAULT = 16'h0000;

  // FSM state encodings, kept as plain constants for compatibility with the
  // older transmit engine sources.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Clocks per bit at 100 MHz for each baud select code.
  function automatic logic [18:0] baud_k(input logic [3:0] sel);
    logic [18:0] k;
    case (sel)
      4'd0:    k = 19'd333333;
      4'd1:    k = 19'd83333;
      4'd2:    k = 19'd41667;
      4'd3:    k = 19'd20833;
      4'd4:    k = 19'd10417;
      4'd5:    k = 19'd5208;
      4'd6:    k = 19'd2604;
      4'd7:    k = 19'd1736;
      4'd8:    k = 19'd868;
      4'd9:    k = 19'd434;
      4'd10:   k = 19'd217;
      default: k = 19'd109;
    endcase
    return k;
  endfunction

  // XOR-reduction of a data byte (1 when the byte holds an odd number of ones).
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-time down-counter for the receiver. Loading a value L makes tick
// assert L clocks after the load edge, so a reload on every tick yields a
// period of exactly L clocks.
module rx_bit_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [18:0] load_val,
  output logic        tick
);

  logic [18:0] cnt_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= 19'd0;
    end else if (load) begin
      cnt_r <= (load_val == 19'd0) ? 19'd0 : (load_val - 19'd1);
    end else if (cnt_r != 19'd0) begin
      cnt_r <= cnt_r - 19'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = (cnt_r == 19'd0);

endmodule

// File: rtl/rx_engine.sv
// UART receiver for the TramelBlaze I/O bus: synchronises rx, samples each
// bit at mid-bit, rebuilds 7/8-bit frames with optional parity and reports
// parity, framing and overrun errors. A CPU read of the data port clears
// rx_rdy and ovf.
module rx_engine
  import rx_engine_pkg::*;
#(
  parameter logic [15:0] RX_DATA_PORT = RX_DATA_PORT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] port_id,
  input  logic        read_strobe,
  input  logic [3:0]  baud_in,
  input  logic        Eight,
  input  logic        Pen,
  input  logic        OHEL,
  input  logic        rx,
  output logic        rx_rdy,
  output logic [7:0]  rx_data,
  output logic        pe,
  output logic        fe,
  output logic        ovf
);

  logic        rx_meta_r, rx_sync_r;
  logic [1:0]  state_r, state_s;
  logic [3:0]  baud_r;
  logic        eight_r, pen_r, ohel_r;
  logic        armed_r;
  logic [10:0] sr_r;
  logic [3:0]  bit_cnt_r;
  logic [3:0]  nsamp_s;
  logic        tick_s, tmr_load_s;
  logic [18:0] tmr_val_s, k_new_s;
  logic [10:0] aligned_s;
  logic [7:0]  data_s;
  logic        par_bit_s, stop_s, pe_s, rd_s, done_s;

  rx_bit_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tick     (tick_s)
  );

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Samples taken after the start bit: data bits, optional parity, stop.
  assign nsamp_s = 4'd8 + {3'd0, eight_r} + {3'd0, pen_r};
  assign k_new_s = baud_k(baud_in);

  // Next-state and timer-load decisions.
  always_comb begin
    state_s    = state_r;
    tmr_load_s = 1'b0;
    tmr_val_s  = baud_k(baud_r);
    case (state_r)
      ST_IDLE: begin
        if (armed_r && !rx_sync_r) begin
          state_s    = ST_START;
          tmr_load_s = 1'b1;
          tmr_val_s  = {1'b0, k_new_s[18:1]};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          tmr_load_s = 1'b1;
          state_s    = rx_sync_r ? ST_IDLE : ST_SHIFT;
        end else begin
          state_s = ST_START;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          tmr_load_s = 1'b1;
          state_s    = ((bit_cnt_r + 4'd1) == nsamp_s) ? ST_DONE : ST_SHIFT;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Realign the right-shifted samples so data starts at bit 0, then derive
  // the parity and stop bits from the frame format latched at start.
  always_comb begin
    aligned_s = sr_r >> (4'd11 - nsamp_s);
    data_s    = {eight_r & aligned_s[7], aligned_s[6:0]};
    par_bit_s = eight_r ? aligned_s[8] : aligned_s[7];
    stop_s    = aligned_s[nsamp_s - 4'd1];
    pe_s      = pen_r & (parity8(data_s) ^ par_bit_s ^ ohel_r);
  end

  // FSM state, frame config latch, sample shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= 4'd0;
      eight_r   <= 1'b0;
      pen_r     <= 1'b0;
      ohel_r    <= 1'b0;
      sr_r      <= 11'd0;
      bit_cnt_r <= 4'd0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE && state_s == ST_START) begin
        baud_r  <= baud_in;
        eight_r <= Eight;
        pen_r   <= Pen;
        ohel_r  <= OHEL;
      end
      if (state_r == ST_START && tick_s) begin
        bit_cnt_r <= 4'd0;
      end else if (state_r == ST_SHIFT && tick_s) begin
        sr_r      <= {rx_sync_r, sr_r[10:1]};
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
    end
  end

  // After a frame whose stop bit was low (e.g. a break), stay disarmed until
  // the line is seen high again so a held-low line yields a single frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_r <= 1'b1;
    end else if (rx_sync_r) begin
      armed_r <= 1'b1;
    end else if (state_r == ST_DONE && !stop_s) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= armed_r;
    end
  end

  assign rd_s   = read_strobe & (port_id == RX_DATA_PORT);
  assign done_s = (state_r == ST_DONE);

  // CPU-visible registers: a read in the same clock as frame completion is
  // applied first, so the new frame is flagged ready without an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_rdy  <= 1'b0;
      rx_data <= 8'h00;
      pe      <= 1'b0;
      fe      <= 1'b0;
      ovf     <= 1'b0;
    end else if (done_s) begin
      rx_data <= data_s;
      pe      <= pe_s;
      fe      <= ~stop_s;
      rx_rdy  <= 1'b1;
      ovf     <= (ovf | rx_rdy) & ~rd_s;
    end else begin
      rx_rdy  <= rx_rdy & ~rd_s;
      ovf     <= ovf & ~rd_s;
    end
  end

endmodule
